multi_key_debouncer: RTL and testbench

Parametrised N-channel push-button conditioner that replaces single-key debouncing across the board's key inputs. Each channel synchronises its raw input, debounces it, and emits a debounced level plus single-cycle press, release, long-press and auto-repeat pulses. It sits between the board key pins and the control FSMs, so those FSMs consume clean one-cycle events only.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_channel.sv | 134 +++++++++++++
 rtl/multi_key_debouncer.sv | 45 ++++
 tb/tb_multi_key_debouncer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-key debouncer: per-channel FSM states
// and the counter width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    REPEAT  = 2'd2,
    LATCHED = 2'd3
  } key_state_t;

  // Bits needed for a counter that runs 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, polarity normalisation, debounce counter
// and the press/hold/long/repeat FSM. All event outputs are single-cycle registered pulses.
module key_channel
  import key_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_in,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [1:0] state_dbg
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES);
  localparam logic          PIN_RELEASED = ACTIVE_LOW;
  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST    = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST     = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          sync_1, sync_2, sync;
  logic [DW-1:0] db_cnt;
  logic          commit, rise, fall;

  key_state_t    state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          long_next, repeat_next;

  // Synchroniser resets to the released pin level so reset release is never a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= PIN_RELEASED;
      sync_2 <= PIN_RELEASED;
    end else begin
      sync_1 <= key_in;
      sync_2 <= sync_1;
    end
  end

  assign sync   = ACTIVE_LOW ? ~sync_2 : sync_2;
  assign commit = (sync != key_level) && (db_cnt == DB_LAST);
  assign rise   = commit && sync;
  assign fall   = commit && !sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt        <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      if (sync == key_level) begin
        db_cnt <= '0;
      end else if (commit) begin
        db_cnt    <= '0;
        key_level <= sync;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      long_pulse   <= long_next;
      repeat_pulse <= repeat_next;
    end
  end

  // A release edge overrides everything, so no long/repeat pulse can land on it.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    if (fall) begin
      state_next = IDLE;
      hold_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = HOLD;
            hold_next  = '0;
          end
        end
        HOLD: begin
          if (hold_cnt == LONG_LAST) begin
            long_next  = 1'b1;
            hold_next  = '0;
            state_next = (REPEAT_CYCLES > 0) ? REPEAT : LATCHED;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
        REPEAT: begin
          if (hold_cnt == REP_LAST) begin
            repeat_next = 1'b1;
            hold_next   = '0;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
        LATCHED: begin
          hold_next = '0;
        end
        default: begin
          state_next = IDLE;
          hold_next  = '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/multi_key_debouncer.sv
// N independent key channels; any_press is the OR of the registered press pulses.
// state_dbg packs each channel's FSM state, two bits per channel.
module multi_key_debouncer
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_KEYS-1:0]     key_in,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     press_pulse,
  output logic [N_KEYS-1:0]     release_pulse,
  output logic [N_KEYS-1:0]     long_pulse,
  output logic [N_KEYS-1:0]     repeat_pulse,
  output logic                  any_press,
  output logic [2*N_KEYS-1:0]   state_dbg
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_in       (key_in[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .state_dbg    (state_dbg[2*i +: 2])
    );
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Bench for multi_key_debouncer: two DUTs (repeat enabled / disabled) share the key pins
// and are checked every cycle against an event-level reference model.
module tb_multi_key_debouncer;
  import key_pkg::*;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] key_in = 2'b11;

  logic [1:0] lvl_a, prs_a, rel_a, lng_a, rep_a, lvl_b, prs_b, rel_b, lng_b, rep_b;
  logic       any_a, any_b;
  logic [3:0] st_a, st_b;

  int checks = 0;
  int failures = 0;

  // reference model state: [dut][key]
  bit         p1 [2][2];
  bit         p2 [2][2];
  bit         m_lvl [2][2];
  int         run [2][2];
  bit         held_on [2][2];
  int         held [2][2];
  int         rep_cfg [2];
  logic [1:0] e_lvl [2];
  logic [1:0] e_prs [2];
  logic [1:0] e_rel [2];
  logic [1:0] e_lng [2];
  logic [1:0] e_rep [2];

  multi_key_debouncer #(.N_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut_a (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_level(lvl_a),
    .press_pulse(prs_a), .release_pulse(rel_a), .long_pulse(lng_a),
    .repeat_pulse(rep_a), .any_press(any_a), .state_dbg(st_a));

  multi_key_debouncer #(.N_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L), .REPEAT_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_level(lvl_b),
    .press_pulse(prs_b), .release_pulse(rel_b), .long_pulse(lng_b),
    .repeat_pulse(rep_b), .any_press(any_b), .state_dbg(st_b));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        p1[d][k] = 1'b0; p2[d][k] = 1'b0; m_lvl[d][k] = 1'b0;
        run[d][k] = 0; held_on[d][k] = 1'b0; held[d][k] = 0;
      end
      e_lvl[d] = '0; e_prs[d] = '0; e_rel[d] = '0; e_lng[d] = '0; e_rep[d] = '0;
    end
  endtask

  // One clock edge of the spec's rules: sync lags the pin by two samples, a level
  // change needs D consecutive differing cycles, and pulses follow from time held.
  task automatic model_edge(input logic [1:0] keys);
    bit s;
    for (int d = 0; d < 2; d++) begin
      e_prs[d] = '0; e_rel[d] = '0; e_lng[d] = '0; e_rep[d] = '0;
      for (int k = 0; k < 2; k++) begin
        s = p2[d][k];
        p2[d][k] = p1[d][k];
        p1[d][k] = ~keys[k];
        if (s != m_lvl[d][k]) begin
          run[d][k]++;
        end else begin
          run[d][k] = 0;
        end
        if (run[d][k] == D) begin
          run[d][k] = 0;
          m_lvl[d][k] = s;
          if (s) begin
            e_prs[d][k] = 1'b1; held_on[d][k] = 1'b1; held[d][k] = 0;
          end else begin
            e_rel[d][k] = 1'b1; held_on[d][k] = 1'b0;
          end
        end else if (held_on[d][k]) begin
          held[d][k]++;
          if (held[d][k] == L) e_lng[d][k] = 1'b1;
          else if (rep_cfg[d] > 0 && held[d][k] > L && ((held[d][k] - L) % rep_cfg[d]) == 0)
            e_rep[d][k] = 1'b1;
        end
        e_lvl[d][k] = m_lvl[d][k];
      end
    end
  endtask

  task automatic compare_all();
    check("a.level",   32'(lvl_a), 32'(e_lvl[0]));
    check("a.press",   32'(prs_a), 32'(e_prs[0]));
    check("a.release", 32'(rel_a), 32'(e_rel[0]));
    check("a.long",    32'(lng_a), 32'(e_lng[0]));
    check("a.repeat",  32'(rep_a), 32'(e_rep[0]));
    check("a.any",     32'(any_a), 32'(|e_prs[0]));
    check("b.level",   32'(lvl_b), 32'(e_lvl[1]));
    check("b.press",   32'(prs_b), 32'(e_prs[1]));
    check("b.release", 32'(rel_b), 32'(e_rel[1]));
    check("b.long",    32'(lng_b), 32'(e_lng[1]));
    check("b.repeat",  32'(rep_b), 32'(e_rep[1]));
    check("b.any",     32'(any_b), 32'(|e_prs[1]));
  endtask

  // driver: apply pins at the falling edge, model the rising edge, compare at the next fall
  task automatic step(input logic [1:0] keys);
    key_in = keys;
    @(posedge clk);
    if (reset_n) model_edge(key_in);
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"}, 32'({lvl_a, prs_a, rel_a, lng_a, rep_a, any_a,
                               lvl_b, prs_b, rel_b, lng_b, rep_b, any_b}), 32'd0);
    check({tag, ".state"}, 32'({st_a, st_b}), 32'({IDLE, IDLE, IDLE, IDLE}));
  endtask

  initial begin
    int c, first_long, n_long_a, n_rep_a, n_long_b, n_rep_b, n_after, seen, acc;
    int seg [2];
    logic [1:0] lvl_rand;

    rep_cfg[0] = R;
    rep_cfg[1] = 0;
    model_reset();

    // reset with pins released, then 50 quiet cycles
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      step(2'b11);
      acc |= int'(|{prs_a, rel_a, lng_a, rep_a, lvl_a});
    end
    check("reset.quiet", 32'(acc), 32'd0);

    // bounce: low 3, high 1, low 3, then high
    acc = 0;
    for (int i = 0; i < 3; i++) begin step(2'b10); acc |= int'(|{prs_a, lvl_a}); end
    step(2'b11); acc |= int'(|{prs_a, lvl_a});
    for (int i = 0; i < 3; i++) begin step(2'b10); acc |= int'(|{prs_a, lvl_a}); end
    for (int i = 0; i < 10; i++) begin step(2'b11); acc |= int'(|{prs_a, lvl_a}); end
    check("bounce.no_change", 32'(acc), 32'd0);

    // latency: pin falls before E0, press visible after E(D+1)
    for (int i = 0; i < D + 1; i++) step(2'b10);
    check("lat.before", 32'({lvl_a, prs_a}), 32'd0);
    step(2'b10);
    check("lat.press", 32'(prs_a), 32'd1);
    check("lat.level", 32'(lvl_a), 32'd1);

    // hold: long at +L, repeats every R cycles after (dut_a), none on dut_b
    first_long = -1; n_long_a = 0; n_rep_a = 0; n_long_b = 0; n_rep_b = 0;
    for (c = 1; c < 60; c++) begin
      step(2'b10);
      if (lng_a[0]) begin n_long_a++; if (first_long < 0) first_long = c; end
      if (rep_a[0]) n_rep_a++;
      if (lng_b[0]) n_long_b++;
      if (rep_b[0]) n_rep_b++;
    end
    check("hold.long_at", 32'(first_long), 32'(L));
    check("hold.a_longs", 32'(n_long_a), 32'd1);
    check("hold.a_repeats", 32'(n_rep_a), 32'd7);
    check("hold.b_longs", 32'(n_long_b), 32'd1);
    check("hold.b_repeats", 32'(n_rep_b), 32'd0);
    check("hold.ch1_idle", 32'({lvl_a[1], lvl_b[1]}), 32'd0);

    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step(2'b11);
      if (rel_a[0]) seen = 1;
    end
    check("release.seen", 32'(seen), 32'd1);
    n_after = 0;
    for (int i = 0; i < 30; i++) begin
      step(2'b11);
      n_after += int'(|{prs_a, rel_a, lng_a, rep_a, prs_b, rel_b, lng_b, rep_b});
    end
    check("release.quiet", 32'(n_after), 32'd0);

    // both keys on the same edge
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      step(2'b00);
      if (prs_a != 2'b00) seen = 1;
    end
    check("both.press", 32'(prs_a), 32'b11);
    check("both.any", 32'(any_a), 32'd1);
    for (int i = 0; i < 10; i++) step(2'b00);

    // reset mid-hold: everything clears at once, no release afterwards
    reset_n = 1'b0;
    key_in = 2'b11;
    #1;
    check_all_zero("midreset");
    model_reset();
    for (int i = 0; i < 3; i++) step(2'b11);
    @(negedge clk);
    reset_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      step(2'b11);
      acc |= int'(|{prs_a, rel_a, lng_a, rep_a, lvl_a, prs_b, rel_b, lng_b, rep_b, lvl_b});
    end
    check("midreset.quiet", 32'(acc), 32'd0);

    // random segments: short bounces mixed with long holds on both channels
    seg[0] = 0; seg[1] = 0;
    lvl_rand = 2'b11;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (seg[k] == 0) begin
          lvl_rand[k] = 1'($urandom_range(0, 1));
          seg[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(6, 90));
        end
        seg[k]--;
      end
      step(lvl_rand);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
